// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared PIO action codes, bridge register map and FSM state type
//
// Purpose: constants shared by the PIO host-side bridge and anything that
// decodes its register window. No ports (package).
package pio_pkg;

    // PIO command interface action codes
    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_PULL  = 4'd3;
    localparam logic [3:0] ACT_PUSH  = 4'd4;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_IMM   = 4'd9;
    localparam logic [3:0] ACT_SHIFT = 4'd10;

    // Global register byte offsets
    localparam logic [11:0] REG_CTRL      = 12'h100;
    localparam logic [11:0] REG_FSTAT     = 12'h104;
    localparam logic [11:0] REG_VERSION   = 12'h108;
    localparam logic [11:0] REG_FLEVEL    = 12'h10C;
    localparam logic [11:0] REG_IRQ_FORCE = 12'h110;
    localparam logic [11:0] REG_INTE0     = 12'h114;
    localparam logic [11:0] REG_INTF0     = 12'h118;
    localparam logic [11:0] REG_INTE1     = 12'h11C;
    localparam logic [11:0] REG_INTF1     = 12'h120;
    localparam logic [11:0] REG_INTS0     = 12'h124;
    localparam logic [11:0] REG_INTS1     = 12'h128;
    localparam logic [11:0] REG_MISC      = 12'h12C;

    // Per-machine window word offsets (paddr[4:2]) inside 0x080 + m*0x20
    localparam logic [2:0] MOFF_PEND  = 3'd0;
    localparam logic [2:0] MOFF_GRPS  = 3'd1;
    localparam logic [2:0] MOFF_DIV   = 3'd2;
    localparam logic [2:0] MOFF_SHIFT = 3'd3;
    localparam logic [2:0] MOFF_TXF   = 3'd4;
    localparam logic [2:0] MOFF_RXF   = 3'd5;
    localparam logic [2:0] MOFF_IMM   = 3'd6;

    // FSTAT field LSB positions
    localparam int FSTAT_TX_EMPTY = 24;
    localparam int FSTAT_TX_FULL  = 16;
    localparam int FSTAT_RX_EMPTY = 8;
    localparam int FSTAT_RX_FULL  = 0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/pio_apb_bridge.sv
// rtl/pio_apb_bridge.sv - APB3 slave driving the PIO action/index/mindex/din/dout command port
//
// Purpose: turns APB register accesses into single-cycle PIO actions, captures
// PULL/VERSION read data, stalls TXF/RXF accesses on full/empty FIFOs with a
// bounded wait, and holds shadow copies of the IRQ enable/force and MISC regs.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata, prdata/pready/pslverr   APB3 slave
//   action/mindex/index/din, dout                             PIO command port
//   tx_full/tx_empty/rx_full/rx_empty, tx_level*/rx_level*    FIFO status
//   irq0_ints/irq1_ints                                       interrupt status
//   irq_force_pulse, irq*_inte/intf, sync_bypass              shadow outputs
module pio_apb_bridge
    import pio_pkg::*;
#(
    parameter int STALL_LIMIT  = 64,
    parameter int NUM_MACHINES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [3:0]  action,
    output logic [1:0]  mindex,
    output logic [4:0]  index,
    output logic [31:0] din,
    input  logic [31:0] dout,
    input  logic [3:0]  tx_full,
    input  logic [3:0]  tx_empty,
    input  logic [3:0]  rx_full,
    input  logic [3:0]  rx_empty,
    input  logic [2:0]  tx_level0,
    input  logic [2:0]  tx_level1,
    input  logic [2:0]  tx_level2,
    input  logic [2:0]  tx_level3,
    input  logic [2:0]  rx_level0,
    input  logic [2:0]  rx_level1,
    input  logic [2:0]  rx_level2,
    input  logic [2:0]  rx_level3,
    input  logic [11:0] irq0_ints,
    input  logic [11:0] irq1_ints,
    output logic [7:0]  irq_force_pulse,
    output logic [11:0] irq0_inte,
    output logic [11:0] irq0_intf,
    output logic [11:0] irq1_inte,
    output logic [11:0] irq1_intf,
    output logic        sync_bypass
);

    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] STALL_MAX = CW'(STALL_LIMIT);

    state_t         r_state, w_next;
    logic [CW-1:0]  r_stall;
    logic [3:0]     r_action;
    logic [1:0]     r_mindex;
    logic [4:0]     r_index;
    logic [31:0]    r_din;
    logic           r_capture;
    logic           r_write;
    logic           r_err;
    logic [31:0]    r_prdata;
    logic [31:0]    r_ctrl;
    logic [11:0]    r_inte0, r_intf0, r_inte1, r_intf1;
    logic           r_sync_bypass;
    logic [7:0]     r_irq_force;

    // Decode results for the access currently on the bus
    logic [11:0]    w_off;
    logic           w_valid;
    logic           w_pio;
    logic [3:0]     w_act;
    logic           w_capture;
    logic           w_fifo;
    logic [1:0]     w_m;
    logic [4:0]     w_index;
    logic [31:0]    w_rdata;
    logic           w_blocked;
    logic           w_wait_blocked;
    logic           w_access;
    logic           w_unused_ok;

    assign w_off          = {paddr[11:2], 2'b00};
    assign w_access       = psel & penable;
    assign w_unused_ok    = &{1'b0, paddr[1:0]};
    assign w_blocked      = w_fifo & (pwrite ? tx_full[w_m] : rx_empty[w_m]);
    // In WAIT the stored machine/direction are used, not the live bus
    assign w_wait_blocked = r_write ? tx_full[r_mindex] : rx_empty[r_mindex];

    always_comb begin
        w_valid   = 1'b0;
        w_pio     = 1'b0;
        w_act     = ACT_NONE;
        w_capture = 1'b0;
        w_fifo    = 1'b0;
        w_m       = 2'd0;
        w_index   = 5'd0;
        w_rdata   = 32'd0;
        if (paddr[11:7] == 5'b00000) begin
            if (pwrite) begin
                w_valid = 1'b1;
                w_pio   = 1'b1;
                w_act   = ACT_INSTR;
                w_index = paddr[6:2];
            end
        end else if (paddr[11:7] == 5'b00001) begin
            w_m = paddr[6:5];
            if (int'(paddr[6:5]) < NUM_MACHINES) begin
                case (paddr[4:2])
                    MOFF_PEND:  if (pwrite) begin w_valid = 1'b1; w_pio = 1'b1; w_act = ACT_PEND;  end
                    MOFF_GRPS:  if (pwrite) begin w_valid = 1'b1; w_pio = 1'b1; w_act = ACT_GRPS;  end
                    MOFF_DIV:   if (pwrite) begin w_valid = 1'b1; w_pio = 1'b1; w_act = ACT_DIV;   end
                    MOFF_SHIFT: if (pwrite) begin w_valid = 1'b1; w_pio = 1'b1; w_act = ACT_SHIFT; end
                    MOFF_IMM:   if (pwrite) begin w_valid = 1'b1; w_pio = 1'b1; w_act = ACT_IMM;   end
                    MOFF_TXF: if (pwrite) begin
                        w_valid = 1'b1; w_pio = 1'b1; w_act = ACT_PUSH; w_fifo = 1'b1;
                    end
                    MOFF_RXF: if (!pwrite) begin
                        w_valid = 1'b1; w_pio = 1'b1; w_act = ACT_PULL; w_fifo = 1'b1;
                        w_capture = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (w_off)
                REG_CTRL: begin
                    w_valid = 1'b1;
                    if (pwrite) begin
                        w_pio = 1'b1;
                        w_act = ACT_EN;
                    end else begin
                        w_rdata = r_ctrl;
                    end
                end
                REG_FSTAT: if (!pwrite) begin
                    w_valid = 1'b1;
                    w_rdata[FSTAT_TX_EMPTY +: 4] = tx_empty;
                    w_rdata[FSTAT_TX_FULL  +: 4] = tx_full;
                    w_rdata[FSTAT_RX_EMPTY +: 4] = rx_empty;
                    w_rdata[FSTAT_RX_FULL  +: 4] = rx_full;
                end
                // VERSION issues a NONE action; PIO presents the version on dout
                REG_VERSION: if (!pwrite) begin
                    w_valid = 1'b1; w_pio = 1'b1; w_capture = 1'b1;
                end
                REG_FLEVEL: if (!pwrite) begin
                    w_valid = 1'b1;
                    w_rdata = {1'b0, rx_level3, 1'b0, tx_level3, 1'b0, rx_level2, 1'b0, tx_level2,
                               1'b0, rx_level1, 1'b0, tx_level1, 1'b0, rx_level0, 1'b0, tx_level0};
                end
                REG_IRQ_FORCE: if (pwrite) w_valid = 1'b1;
                REG_INTE0: begin w_valid = 1'b1; w_rdata = {20'd0, r_inte0}; end
                REG_INTF0: begin w_valid = 1'b1; w_rdata = {20'd0, r_intf0}; end
                REG_INTE1: begin w_valid = 1'b1; w_rdata = {20'd0, r_inte1}; end
                REG_INTF1: begin w_valid = 1'b1; w_rdata = {20'd0, r_intf1}; end
                REG_INTS0: if (!pwrite) begin w_valid = 1'b1; w_rdata = {20'd0, irq0_ints}; end
                REG_INTS1: if (!pwrite) begin w_valid = 1'b1; w_rdata = {20'd0, irq1_ints}; end
                REG_MISC:  begin w_valid = 1'b1; w_rdata = {31'd0, r_sync_bypass}; end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_valid && w_pio)
                        w_next = w_blocked ? ST_WAIT : ST_ISSUE;
                    else
                        w_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!w_wait_blocked)
                    w_next = ST_ISSUE;
                else if (r_stall == STALL_MAX)
                    w_next = ST_RESP;
            end
            ST_ISSUE:   w_next = r_capture ? ST_CAPTURE : ST_RESP;
            ST_CAPTURE: w_next = ST_RESP;
            ST_RESP:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_stall       <= '0;
            r_action      <= ACT_NONE;
            r_mindex      <= 2'd0;
            r_index       <= 5'd0;
            r_din         <= 32'd0;
            r_capture     <= 1'b0;
            r_write       <= 1'b0;
            r_err         <= 1'b0;
            r_prdata      <= 32'd0;
            r_ctrl        <= 32'd0;
            r_inte0       <= 12'd0;
            r_intf0       <= 12'd0;
            r_inte1       <= 12'd0;
            r_intf1       <= 12'd0;
            r_sync_bypass <= 1'b0;
            r_irq_force   <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_irq_force <= 8'd0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_err     <= ~w_valid;
                        r_prdata  <= pwrite ? 32'd0 : w_rdata;
                        r_action  <= w_act;
                        r_mindex  <= w_m;
                        r_index   <= w_index;
                        r_din     <= pwrite ? pwdata : 32'd0;
                        r_capture <= w_capture;
                        r_write   <= pwrite;
                        r_stall   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_wait_blocked) begin
                        if (r_stall == STALL_MAX) begin
                            r_err    <= 1'b1;
                            r_prdata <= 32'd0;
                        end else begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end
                end
                ST_CAPTURE: r_prdata <= dout;
                // Shadow writes commit on the response edge; the bus still
                // holds paddr/pwdata here, so the live decode is reused.
                ST_RESP: begin
                    if (psel && pwrite && !r_err) begin
                        case (w_off)
                            REG_CTRL:      r_ctrl        <= pwdata;
                            REG_IRQ_FORCE: r_irq_force   <= pwdata[7:0];
                            REG_INTE0:     r_inte0       <= pwdata[11:0];
                            REG_INTF0:     r_intf0       <= pwdata[11:0];
                            REG_INTE1:     r_inte1       <= pwdata[11:0];
                            REG_INTF1:     r_intf1       <= pwdata[11:0];
                            REG_MISC:      r_sync_bypass <= pwdata[0];
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Command outputs are only non-zero during ISSUE
    assign action          = (r_state == ST_ISSUE) ? r_action : ACT_NONE;
    assign mindex          = (r_state == ST_ISSUE) ? r_mindex : 2'd0;
    assign index           = (r_state == ST_ISSUE) ? r_index  : 5'd0;
    assign din             = (r_state == ST_ISSUE) ? r_din    : 32'd0;
    assign pready          = (r_state == ST_RESP);
    assign pslverr         = (r_state == ST_RESP) & r_err;
    assign prdata          = (r_state == ST_RESP) ? r_prdata : 32'd0;
    assign irq_force_pulse = r_irq_force;
    assign irq0_inte       = r_inte0;
    assign irq0_intf       = r_intf0;
    assign irq1_inte       = r_inte1;
    assign irq1_intf       = r_intf1;
    assign sync_bypass     = r_sync_bypass;

endmodule

// File: tb/tb_pio_apb_bridge.sv
// tb/tb_pio_apb_bridge.sv - scoreboard bench for pio_apb_bridge
module tb_pio_apb_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic [4:0]  index;
    logic [31:0] din;
    logic [31:0] dout = '0;
    logic [3:0]  tx_full = '0, tx_empty = '0, rx_full = '0, rx_empty = '0;
    logic [2:0]  tx_level0 = 3'd1, tx_level1 = 3'd3, tx_level2 = 3'd5, tx_level3 = 3'd7;
    logic [2:0]  rx_level0 = 3'd2, rx_level1 = 3'd4, rx_level2 = 3'd6, rx_level3 = 3'd0;
    logic [11:0] irq0_ints = 12'h5A5, irq1_ints = 12'h3C3;
    logic [7:0]  irq_force_pulse;
    logic [11:0] irq0_inte, irq0_intf, irq1_inte, irq1_intf;
    logic        sync_bypass;

    pio_apb_bridge dut (
        .clk(clk), .reset(reset),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .action(action), .mindex(mindex), .index(index), .din(din), .dout(dout),
        .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
        .tx_level0(tx_level0), .tx_level1(tx_level1), .tx_level2(tx_level2), .tx_level3(tx_level3),
        .rx_level0(rx_level0), .rx_level1(rx_level1), .rx_level2(rx_level2), .rx_level3(rx_level3),
        .irq0_ints(irq0_ints), .irq1_ints(irq1_ints),
        .irq_force_pulse(irq_force_pulse),
        .irq0_inte(irq0_inte), .irq0_intf(irq0_intf), .irq1_inte(irq1_inte), .irq1_intf(irq1_intf),
        .sync_bypass(sync_bypass)
    );

    always #5 clk = ~clk;

    // PIO model: dout registered; PULL returns a tag carrying the machine, otherwise version
    always @(posedge clk) begin
        if (action == 4'd3) dout <= 32'hCAFE0000 | {30'd0, mindex};
        else                dout <= 32'h01000000;
    end

    typedef struct { logic [31:0] rd; logic err; int lat; logic chk_rd; } rsp_t;
    typedef struct { logic [3:0] act; logic [1:0] m; logic [4:0] idx; logic [31:0] d; } act_t;

    rsp_t        rsp_q[$];
    act_t        act_q[$];
    logic [7:0]  irq_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc = 0;
    rsp_t        mr;
    act_t        ma;
    logic [7:0]  mi;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected nothing", name, got);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response/action/pulse
    always @(negedge clk) begin
        if (psel && penable) acc++;
        else acc = 0;
        if (pready) begin
            if (rsp_q.size() == 0) unexpected("pready", {31'd0, pready});
            else begin
                mr = rsp_q.pop_front();
                chk("pslverr", {31'd0, pslverr}, {31'd0, mr.err});
                if (mr.chk_rd) chk("prdata", prdata, mr.rd);
                if (mr.lat > 0) chk("latency", acc, mr.lat);
            end
        end
        if (action != 4'd0) begin
            if (act_q.size() == 0) unexpected("action", {28'd0, action});
            else begin
                ma = act_q.pop_front();
                chk("action", {28'd0, action}, {28'd0, ma.act});
                chk("mindex", {30'd0, mindex}, {30'd0, ma.m});
                chk("index", {27'd0, index}, {27'd0, ma.idx});
                chk("din", din, ma.d);
            end
        end
        if (irq_force_pulse != 8'd0) begin
            if (irq_q.size() == 0) unexpected("irq_force", {24'd0, irq_force_pulse});
            else begin
                mi = irq_q.pop_front();
                chk("irq_force", {24'd0, irq_force_pulse}, {24'd0, mi});
            end
        end
    end

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input logic eerr, input int elat);
        logic done;
        rsp_t r;
        r.rd = erd; r.err = eerr; r.lat = elat; r.chk_rd = ~wr;
        rsp_q.push_back(r);
        done = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (pready) begin
                done = 1'b1;
                break;
            end
        end
        chk("apb_done", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic exp_act(input logic [3:0] ac, input logic [1:0] m, input logic [4:0] i, input logic [31:0] d);
        act_t e;
        e.act = ac; e.m = m; e.idx = i; e.d = d;
        act_q.push_back(e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_ctl", {26'd0, pready, pslverr, action}, 32'd0);
        chk("rst_cmd", {25'd0, mindex, index}, 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_shadow", {irq0_inte, irq0_intf, irq_force_pulse}, 32'd0);
        chk("rst_shadow1", {7'd0, sync_bypass, irq1_inte, irq1_intf}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // INSTR write, index 2 and index 31
        exp_act(4'd1, 2'd0, 5'd2, 32'h1234);
        apb(1, 12'h008, 32'h1234, 0, 0, 3);
        exp_act(4'd1, 2'd0, 5'd31, 32'h89ABCDEF);
        apb(1, 12'h07C, 32'h89ABCDEF, 0, 0, 3);
        // VERSION read: NONE action, capture
        apb(0, 12'h108, 0, 32'h01000000, 0, 4);
        // PULL machine 3
        exp_act(4'd3, 2'd3, 5'd0, 32'd0);
        apb(0, 12'h0F4, 0, 32'hCAFE0003, 0, 4);
        // DIV machine 2, CTRL write/readback
        exp_act(4'd7, 2'd2, 5'd0, 32'h00020000);
        apb(1, 12'h0C8, 32'h00020000, 0, 0, 3);
        exp_act(4'd6, 2'd0, 5'd0, 32'h5);
        apb(1, 12'h100, 32'h5, 0, 0, 3);
        apb(0, 12'h100, 0, 32'h5, 0, 2);

        // Blocked PUSH on machine 1, released during access cycle 11
        tx_full = 4'b0010;
        exp_act(4'd4, 2'd1, 5'd0, 32'hDEAD0001);
        fork
            apb(1, 12'h0B0, 32'hDEAD0001, 0, 0, 13);
            begin
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk);
                    if (psel && penable) break;
                end
                repeat (10) @(posedge clk);
                #1 tx_full = 4'b0000;
            end
        join

        // Starved PULL on machine 2 times out: error, zero data, no action
        rx_empty = 4'b0100;
        apb(0, 12'h0D4, 0, 32'd0, 1, 67);
        rx_empty = 4'b0000;

        // IRQ force pulse
        irq_q.push_back(8'hA5);
        apb(1, 12'h110, 32'hA5, 0, 0, 2);

        // Shadow registers
        apb(1, 12'h114, 32'hFFF, 0, 0, 2);
        apb(0, 12'h114, 0, 32'hFFF, 0, 2);
        apb(1, 12'h120, 32'hFFFFFABC, 0, 0, 2);
        apb(0, 12'h120, 0, 32'hABC, 0, 2);
        apb(1, 12'h12C, 32'h1, 0, 0, 2);
        apb(0, 12'h12C, 0, 32'h1, 0, 2);
        @(negedge clk);
        chk("irq0_inte", {20'd0, irq0_inte}, 32'hFFF);
        chk("irq1_intf", {20'd0, irq1_intf}, 32'hABC);
        chk("sync_bypass", {31'd0, sync_bypass}, 32'd1);

        // Status reads
        tx_empty = 4'b1010; rx_empty = 4'b0001; rx_full = 4'b0110;
        apb(0, 12'h104, 0, 32'h0A000106, 0, 2);
        rx_empty = 4'b0000;
        apb(0, 12'h10C, 0, 32'h07654321, 0, 2);
        apb(0, 12'h124, 0, 32'h5A5, 0, 2);
        apb(0, 12'h128, 0, 32'h3C3, 0, 2);

        // Errors: write-only read, read-only write, unmapped
        apb(0, 12'h050, 0, 32'd0, 1, 2);
        apb(0, 12'h080, 0, 32'd0, 1, 2);
        apb(1, 12'h104, 32'h1, 0, 1, 2);
        apb(1, 12'h0D4, 32'h1, 0, 1, 2);
        apb(0, 12'h200, 0, 32'd0, 1, 2);
        apb(1, 12'h11C, 32'h7, 0, 0, 2);
        @(negedge clk);
        chk("inte1_after_err", {20'd0, irq1_inte}, 32'h7);

        // Reset during WAIT: everything returns to zero, no action or response
        rx_empty = 4'b0100;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h0D4;
        @(posedge clk); #1 penable = 1'b1;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("rstw_ctl", {26'd0, pready, pslverr, action}, 32'd0);
        chk("rstw_shadow", {irq0_inte, irq0_intf, irq_force_pulse}, 32'd0);
        chk("rstw_misc", {7'd0, sync_bypass, irq1_inte, irq1_intf}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        rx_empty = 4'b0000;
        repeat (5) @(posedge clk);
        apb(0, 12'h114, 0, 32'd0, 0, 2);

        repeat (4) @(posedge clk);
        chk("rsp_q_left", rsp_q.size(), 32'd0);
        chk("act_q_left", act_q.size(), 32'd0);
        chk("irq_q_left", irq_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pio_apb_bridge.md
# pio_apb_bridge

APB3 slave that acts as the host-side initiator of the PIO block's action/index/mindex/din/dout command interface. It turns CPU register reads and writes into single-cycle PIO actions, and it captures PULL and version data. It also adds FIFO flow control, holding off or erroring the bus when a FIFO is full or empty, and keeps shadow copies of the interrupt enable/force registers and `sync_bypass`. It sits between the SoC APB fabric and the `pio` top.

## Interface
Parameters:
- `STALL_LIMIT`, default 64: maximum wait cycles on a blocked TXF/RXF access before it errors.
- `NUM_MACHINES`, default 4: number of state machines, each with its own register window.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; clock `clk`
- `psel`, `penable`, `pwrite`  in  1  APB3 control
- `paddr`  in  12  byte address; bits [1:0] are ignored
- `pwdata`  in  32  write data
- `prdata`  out  32  read data, valid while `pready`=1
- `pready`  out  1  transfer complete
- `pslverr`  out  1  error, valid while `pready`=1
- `action`  out  4  PIO action code (see Operation)
- `mindex`  out  2  target machine
- `index`  out  5  instruction memory slot
- `din`  out  32  PIO command data
- `dout`  in  32  PIO read data; registered inside PIO
- `tx_full`, `tx_empty`, `rx_full`, `rx_empty`  in  4  per-machine FIFO status
- `tx_level0..3`, `rx_level0..3`  in  3 each  FIFO fill levels
- `irq0_ints`, `irq1_ints`  in  12  masked interrupt status
- `irq_force_pulse`  out  8  one-cycle IRQ force strobe
- `irq0_inte`, `irq0_intf`, `irq1_inte`, `irq1_intf`  out  12  shadow registers
- `sync_bypass`  out  1  shadow register

## Operation
Action codes: NONE=0, INSTR=1, PEND=2, PULL=3, PUSH=4, GRPS=5, EN=6, DIV=7, IMM=9, SHIFT=10.

Address map (W = write, R = read):
- `0x000-0x07C`: W → INSTR; `index` = `paddr[6:2]`; `din` = `pwdata`.
- Machine m window at `0x080 + m*0x20`:
  - `+0x00` W → PEND
  - `+0x04` W → GRPS
  - `+0x08` W → DIV
  - `+0x0C` W → SHIFT
  - `+0x10` TXF: W → PUSH
  - `+0x14` RXF: R → PULL
  - `+0x18` W → IMM
- `0x100` CTRL: W → EN. R returns the shadow of the last value written.
- `0x104` FSTAT (R):
  - [27:24] `tx_empty`
  - [19:16] `tx_full`
  - [11:8] `rx_empty`
  - [3:0] `rx_full`
- `0x108` VERSION (R): issues NONE and captures `dout` (PIO returns 0x01000000).
- `0x10C` FLEVEL (R): `{rx_level3, tx_level3, ... , rx_level0, tx_level0}`, each field zero-extended to 4 bits, with machine 0 in the low byte.
- `0x110` IRQ_FORCE (W): `pwdata[7:0]` is pulsed on `irq_force_pulse` for one cycle.
- `0x114`, `0x118`, `0x11C`, `0x120`: INTE0, INTF0, INTE1, INTF1 (R/W, 12 bits).
- `0x124` INTS0 and `0x128` INTS1 (R): the `irq0_ints` and `irq1_ints` inputs.
- `0x12C` MISC (R/W): bit 0 = `sync_bypass`.

Errors and unused bits:
- Unmapped address, read of a write-only register, or write of a read-only register: `pslverr`=1, no side effect.
- Reads of write-only PIO config registers are errors.
- Unused read bits return 0.

FSM states: IDLE, WAIT, ISSUE, CAPTURE, RESP.
- IDLE, when `psel & penable` and not in RESP:
  - TXF write with `tx_full[m]`=1, or RXF read with `rx_empty[m]`=1 → WAIT; clear the stall counter.
  - PIO action → ISSUE; load `action`/`mindex`/`index`/`din`.
  - Local register → RESP.
- WAIT, re-evaluated each cycle:
  - FIFO condition clears → ISSUE.
  - Counter reaches `STALL_LIMIT` → RESP with `pslverr`=1 and no action; a read returns 0.
- ISSUE: drive `action` for exactly one cycle. Then go to CAPTURE for PULL/VERSION, otherwise RESP.
- CAPTURE: `prdata <= dout` → RESP.
- RESP: `pready`=1 for one cycle → IDLE. `action` is NONE in every state except ISSUE.

## Timing
- Reset: all outputs 0 and FSM in IDLE; shadow registers and `sync_bypass` are 0. Reset mid-transfer aborts with no pulse.
- Local register access: `pready` in the 2nd access cycle (1 wait state).
- PIO write: `action` is valid in the 2nd access cycle and `pready` in the 3rd.
- PULL/VERSION: `action` in the 2nd cycle, capture in the 3rd, `pready` in the 4th.
- Blocked access: completes at the earliest 1 cycle after the FIFO condition clears, and no later than `STALL_LIMIT`+2 cycles after access.
- FIFO status is sampled in IDLE/WAIT only. The mandatory IDLE gap between back-to-back transfers guarantees the flags reflect the prior push or pull.
- Shadow register writes take effect on the RESP edge.

## Structure
- Shared `pio_pkg` holds:
  - action code localparams
  - register offsets
  - FSTAT bit positions
- A single module; a separate address decoder is not warranted.
- The stall counter is $clog2(`STALL_LIMIT`+1) bits wide.

## Test plan
- Write `0x1234` to `0x008` → `action`=1 and `index`=2 and `din`=`0x1234` for exactly one cycle; `pready` in the 3rd access cycle; `pslverr`=0.
- Read `0x108` → `action`=0, `prdata`=`0x01000000` in the 4th cycle.
- With `tx_full[1]`=1, write `0x0B0` for 10 cycles, then drop `tx_full` → PUSH issued with `mindex`=1 on the cycle after the drop; `pslverr`=0.
- With `rx_empty[2]`=1 held, read `0x0D4` → after `STALL_LIMIT` (64) cycles, `pready`=1, `pslverr`=1, `prdata`=0, no PULL issued.
- Write `0xA5` to `0x110` → `irq_force_pulse`=`0xA5` for one cycle, then 0.
- Write `0x114`=`0xFFF`, read back `0x114` → `0xFFF`. Read `0x050` → `pslverr`=1. Assert `reset` during a pending WAIT → all outputs 0 and no action issued.
